// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, default timing constants and the
// odd-parity helper used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_START_CYCLES   = 100;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_SYNC_STAGES    = 2;

    // The parity bit makes the total count of ones across data and parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the asynchronous keyboard clock and data lines into the system
// clock domain and flags each falling edge of the keyboard clock exactly once.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_kb_in,
    input  logic data_kb_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [STAGES-1:0] clk_sr;
    logic [STAGES-1:0] data_sr;
    logic              clk_prev;

    // Reset to the idle (pulled-up) level so no spurious edge appears after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[STAGES-2:0], clk_kb_in};
            data_sr  <= {data_sr[STAGES-2:0], data_kb_in};
            clk_prev <= clk_sr[STAGES-1];
        end
    end

    assign clk_sync  = clk_sr[STAGES-1];
    assign data_sync = data_sr[STAGES-1];
    assign clk_fall  = clk_prev & ~clk_sr[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on the device-generated clock, then checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       clk_kb_in,
    input  logic       data_kb_in,
    output logic       clk_kb_oe,
    output logic       data_kb_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam logic [15:0] INHIBIT_LAST = 16'(INHIBIT_CYCLES - 1);
    localparam logic [15:0] START_LAST   = 16'(START_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic clk_sync, data_sync, clk_fall;

    tx_state_t   state, state_n;
    logic [15:0] phase_cnt, phase_n;
    logic [19:0] to_cnt, to_n;
    logic [3:0]  idx, idx_n;
    logic [9:0]  frame, frame_n;
    logic        ack_err, ack_err_n;
    logic        timed_out, timed_out_n;
    logic        clk_oe_n, data_oe_n;
    logic        timeout_hit;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .clk_kb_in  (clk_kb_in),
        .data_kb_in (data_kb_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            to_cnt     <= '0;
            idx        <= '0;
            frame      <= '0;
            ack_err    <= 1'b0;
            timed_out  <= 1'b0;
            clk_kb_oe  <= 1'b0;
            data_kb_oe <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            to_cnt     <= to_n;
            idx        <= idx_n;
            frame      <= frame_n;
            ack_err    <= ack_err_n;
            timed_out  <= timed_out_n;
            clk_kb_oe  <= clk_oe_n;
            data_kb_oe <= data_oe_n;
        end
    end

    assign timeout_hit = ((state == SEND) || (state == ACK)) && (to_cnt == TIMEOUT_LAST);

    // Device clock edges are only acted on in SEND/ACK; while inhibited the device cannot clock.
    always_comb begin
        state_n     = state;
        phase_n     = phase_cnt;
        to_n        = to_cnt;
        idx_n       = idx;
        frame_n     = frame;
        ack_err_n   = ack_err;
        timed_out_n = timed_out;
        clk_oe_n    = clk_kb_oe;
        data_oe_n   = data_kb_oe;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    frame_n     = {1'b1, odd_parity(tx_data), tx_data};
                    idx_n       = '0;
                    phase_n     = '0;
                    ack_err_n   = 1'b0;
                    timed_out_n = 1'b0;
                    clk_oe_n    = 1'b1;
                    state_n     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase_cnt == INHIBIT_LAST) begin
                    phase_n   = '0;
                    data_oe_n = 1'b1;
                    state_n   = START;
                end else begin
                    phase_n = phase_cnt + 16'd1;
                end
            end
            START: begin
                if (phase_cnt == START_LAST) begin
                    clk_oe_n = 1'b0;
                    to_n     = '0;
                    state_n  = SEND;
                end else begin
                    phase_n = phase_cnt + 16'd1;
                end
            end
            SEND, ACK: begin
                to_n = to_cnt + 20'd1;
                if (timeout_hit) begin
                    clk_oe_n    = 1'b0;
                    data_oe_n   = 1'b0;
                    timed_out_n = 1'b1;
                    state_n     = WAIT_IDLE;
                end else if (clk_fall) begin
                    if (state == SEND) begin
                        data_oe_n = ~frame[idx];
                        idx_n     = idx + 4'd1;
                        if (idx == 4'd9) begin
                            state_n = ACK;
                        end
                    end else begin
                        ack_err_n = data_sync;
                        state_n   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign tx_timeout = timeout_hit;
    assign tx_done    = (state == WAIT_IDLE) && clk_sync && data_sync && !timed_out;
    assign tx_ack_err = tx_done && ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: an open-drain bus with a behavioural keyboard that clocks
// host frames in, compared against frames built from the byte and its parity rule.
module tb_ps2_host_tx;

    localparam int INH   = 50;
    localparam int STRT  = 10;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       clk_kb_oe, data_kb_oe;
    logic       busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk_low, dev_data_low;
    logic       clk_line, data_line;

    int checks   = 0;
    int fails    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int tmo_cnt  = 0;

    assign clk_line  = !(clk_kb_oe || dev_clk_low);
    assign data_line = !(data_kb_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_CYCLES   (STRT),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .clk_kb_in  (clk_line),
        .data_kb_in (data_line),
        .clk_kb_oe  (clk_kb_oe),
        .data_kb_oe (data_kb_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected wire bits, start bit first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (tx_done)    done_cnt++;
            if (tx_timeout) tmo_cnt++;
            if (tx_ack_err) begin
                err_cnt++;
                checkOutput("ack_err_with_done", {31'd0, tx_done}, 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_back", {31'd0, n < LIMIT}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit hold, input logic [7:0] next_b);
        int n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("accept_clk_oe", {31'd0, clk_kb_oe}, 32'd1);
        checkOutput("accept_busy", {31'd0, busy}, 32'd1);
        if (hold) tx_data = next_b;
        else      tx_valid = 1'b0;
        n = 0;
        while (!data_kb_oe && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("inhibit_len", {31'd0, (n >= INH - 1) && (n <= INH + 1)}, 32'd1);
        checkOutput("clk_held_at_start", {31'd0, clk_kb_oe}, 32'd1);
    endtask

    // Keyboard model: clocks `edges` falls, reading the host's data on each rising edge.
    task automatic device_frame(input int edges, input bit ack_low, output logic [10:0] bits);
        int n = 0;
        bits = '0;
        while (!(clk_line && !data_line) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("start_seen", {31'd0, n < LIMIT}, 32'd1);
        if (n >= LIMIT) return;
        bits[0] = data_line;
        for (int k = 1; k <= edges && k <= 10; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = data_line;
        end
        if (edges >= 11) begin
            repeat (HALF / 2) @(negedge clk);
            dev_data_low = ack_low;
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack_low, input string tag);
        logic [10:0] bits;
        int d0 = done_cnt;
        int e0 = err_cnt;
        fork
            applyStimulus(b, 1'b0, 8'h00);
            device_frame(11, ack_low, bits);
        join
        wait_ready();
        checkOutput({tag, "_bits"}, {21'd0, bits}, {21'd0, frame_of(b)});
        checkOutput({tag, "_done"}, done_cnt - d0, 32'd1);
        checkOutput({tag, "_ack_err"}, err_cnt - e0, ack_low ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  rb;
        bit          rack;
        int          n, d0, t0;

        rst          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_oe", {30'd0, clk_kb_oe, data_kb_oe}, 32'd0);
        checkOutput("rst_pulses", {29'd0, tx_done, tx_ack_err, tx_timeout}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(8'hED, 1'b1, "ed");
        run_frame(8'h00, 1'b0, "nack00");

        $display("[TB] timeout scenario");
        d0 = done_cnt;
        t0 = tmo_cnt;
        applyStimulus(8'h55, 1'b0, 8'h00);
        n = 0;
        while (clk_kb_oe && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_timeout && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_delay", {31'd0, (n >= TMO - 3) && (n <= TMO + 2)}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("timeout_oe", {30'd0, clk_kb_oe, data_kb_oe}, 32'd0);
        wait_ready();
        checkOutput("timeout_pulses", tmo_cnt - t0, 32'd1);
        checkOutput("timeout_no_done", done_cnt - d0, 32'd0);

        $display("[TB] held tx_valid scenario");
        d0 = done_cnt;
        fork
            applyStimulus(8'hAA, 1'b1, 8'hF4);
            device_frame(11, 1'b1, bits);
        join
        checkOutput("hold_first_bits", {21'd0, bits}, {21'd0, frame_of(8'hAA)});
        wait_ready();
        @(posedge clk);
        #1;
        checkOutput("hold_second_accept", {31'd0, clk_kb_oe}, 32'd1);
        tx_valid = 1'b0;
        device_frame(11, 1'b1, bits);
        wait_ready();
        checkOutput("hold_second_bits", {21'd0, bits}, {21'd0, frame_of(8'hF4)});
        checkOutput("hold_done", done_cnt - d0, 32'd2);

        $display("[TB] mid-frame reset scenario");
        fork
            applyStimulus(8'h0F, 1'b0, 8'h00);
            device_frame(5, 1'b1, bits);
        join
        checkOutput("pre_rst_bits", {26'd0, bits[5:0]}, {26'd0, frame_of(8'h0F) & 11'h03F});
        checkOutput("pre_rst_data_oe", {31'd0, data_kb_oe}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_oe", {30'd0, clk_kb_oe, data_kb_oe}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        run_frame(8'hFF, 1'b1, "after_rst");

        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            run_frame(rb, rack, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
